reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 157 +++++++++++++++
 tb/tb_reaction_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Reaction timer: random LFSR delay, stimulus prompt, millisecond reaction measurement.
// Optional best-time tracking via `define REACTION_BEST_EN (adds best_ms output).
module reaction_timer #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          DELAY_MIN_MS = 1000,
  parameter int          DELAY_MASK   = 4095,
  parameter int          TIMEOUT_MS   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        start,
  input  logic        react,
  output logic        stim_led,
  output logic        busy,
  output logic [13:0] result_ms,
  output logic [1:0]  status,
  output logic        result_valid
`ifdef REACTION_BEST_EN
  ,
  output logic [13:0] best_ms
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_DONE
  } state_t;

  localparam logic [12:0] MinDly = 13'(DELAY_MIN_MS);
  localparam logic [15:0] DlyMsk = 16'(DELAY_MASK);
  localparam logic [13:0] TmoMs  = 14'(TIMEOUT_MS);
  localparam logic [13:0] TmoM1  = 14'(TIMEOUT_MS - 1);

  localparam logic [1:0] StNone  = 2'b00;
  localparam logic [1:0] StOk    = 2'b01;
  localparam logic [1:0] StEarly = 2'b10;
  localparam logic [1:0] StTmo   = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [12:0] delay_q, delay_d;
  logic [13:0] elapsed_q, elapsed_d;
  logic        stim_q, stim_d;
  logic [13:0] res_q, res_d;
  logic [1:0]  status_q, status_d;
  logic        valid_q, valid_d;
  logic [12:0] delay_load;

  // Fibonacci taps 16,14,13,11; free-running so the delay depends on start timing
  assign lfsr_d = {lfsr_q[14:0],
                   lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign delay_load = MinDly + 13'(lfsr_q & DlyMsk);

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    elapsed_d = elapsed_q;
    stim_d    = stim_q;
    res_d     = res_q;
    status_d  = status_q;
    valid_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_WAIT;
          delay_d  = delay_load;
          status_d = StNone;
        end
      end
      S_WAIT: begin
        // an early press beats a coincident final tick
        if (react) begin
          state_d  = S_DONE;
          res_d    = '0;
          status_d = StEarly;
          valid_d  = 1'b1;
          stim_d   = 1'b0;
        end else if (tick_in) begin
          if (delay_q == 13'd1) begin
            state_d   = S_GO;
            stim_d    = 1'b1;
            elapsed_d = '0;
          end else begin
            delay_d = delay_q - 13'd1;
          end
        end
      end
      S_GO: begin
        if (react) begin
          state_d  = S_DONE;
          res_d    = elapsed_q;
          status_d = StOk;
          valid_d  = 1'b1;
          stim_d   = 1'b0;
        end else if (tick_in) begin
          if (elapsed_q == TmoM1) begin
            state_d  = S_DONE;
            res_d    = TmoMs;
            status_d = StTmo;
            valid_d  = 1'b1;
            stim_d   = 1'b0;
          end else begin
            elapsed_d = elapsed_q + 14'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      delay_q   <= '0;
      elapsed_q <= '0;
      stim_q    <= 1'b0;
      res_q     <= '0;
      status_q  <= StNone;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      delay_q   <= delay_d;
      elapsed_q <= elapsed_d;
      stim_q    <= stim_d;
      res_q     <= res_d;
      status_q  <= status_d;
      valid_q   <= valid_d;
    end
  end

`ifdef REACTION_BEST_EN
  logic [13:0] best_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= 14'h3FFF;
    end else if (valid_d && status_d == StOk && res_d < best_q) begin
      best_q <= res_d;
    end
  end

  assign best_ms = best_q;
`endif

  assign stim_led     = stim_q;
  assign busy         = (state_q == S_WAIT) || (state_q == S_GO);
  assign result_ms    = res_q;
  assign status       = status_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: table of rounds plus reset-abort sequence.
// Define REACTION_BEST_EN to also check best_ms.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_in = 1'b0;
  logic        start = 1'b0;
  logic        react = 1'b0;
  logic        stim_led;
  logic        busy;
  logic [13:0] result_ms;
  logic [1:0]  status;
  logic        result_valid;
`ifdef REACTION_BEST_EN
  logic [13:0] best_ms;
  int          best_exp = 16383;
`endif

  reaction_timer dut (
    .clk          (clk),
    .rst          (rst),
    .tick_in      (tick_in),
    .start        (start),
    .react        (react),
    .stim_led     (stim_led),
    .busy         (busy),
    .result_ms    (result_ms),
    .status       (status),
    .result_valid (result_valid)
`ifdef REACTION_BEST_EN
    ,
    .best_ms      (best_ms)
`endif
  );

  always #5 clk = ~clk;

  // reference LFSR, taps 16,14,13,11, same reset and clock as the design
  logic [15:0] m;
  always @(posedge clk or posedge rst)
    if (rst) m <= 16'hACE1;
    else     m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  bit stim_seen = 0;

  typedef struct {
    bit         early;
    int         n;
    bit         tkr;
    logic [1:0] st;
    int         res;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic tk, input logic st, input logic rc);
    tick_in = tk;
    start   = st;
    react   = rc;
    @(posedge clk);
    #1;
    tick_in = 1'b0;
    start   = 1'b0;
    react   = 1'b0;
    if (result_valid) vcount++;
    if (stim_led) stim_seen = 1'b1;
  endtask

  task automatic run(input int idx);
    vec_t v;
    int d, cnt, nn;
    v = tbl[idx];
    d = 1000 + int'(m & 16'h0FFF);
    vcount = 0;
    stim_seen = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    check($sformatf("r%0d_busy_wait", idx), int'(busy), 1);
    check($sformatf("r%0d_status_clr", idx), int'(status), 0);
    if (v.early) begin
      nn = (v.n == -2) ? d - 1 : v.n;
      repeat (nn) step(1'b1, 1'b0, 1'b0);
      step(v.tkr, 1'b0, 1'b1);
      check($sformatf("r%0d_no_stim", idx), int'(stim_seen), 0);
    end else begin
      cnt = 0;
      while (!stim_led && cnt < 6000) begin
        step(1'b1, cnt == 500, 1'b0);
        cnt++;
      end
      check($sformatf("r%0d_delay", idx), cnt, d);
      check($sformatf("r%0d_delay_rng", idx),
            int'(cnt >= 1000 && cnt <= 5095), 1);
      check($sformatf("r%0d_busy_go", idx), int'(busy), 1);
      if (v.n < 0) begin
        cnt = 0;
        while (!result_valid && cnt < 11000) begin
          step(1'b1, cnt == 7, 1'b0);
          cnt++;
        end
        check($sformatf("r%0d_tmo_ticks", idx), cnt, 9999);
      end else begin
        for (int i = 0; i < v.n; i++) step(1'b1, i == 5, 1'b0);
        step(v.tkr, 1'b0, 1'b1);
      end
    end
    check($sformatf("r%0d_status", idx), int'(status), int'(v.st));
    check($sformatf("r%0d_result", idx), int'(result_ms), v.res);
    check($sformatf("r%0d_valid", idx), int'(result_valid), 1);
    check($sformatf("r%0d_stim_off", idx), int'(stim_led), 0);
    check($sformatf("r%0d_busy_done", idx), int'(busy), 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check($sformatf("r%0d_valid_pulse", idx), int'(result_valid), 0);
    check($sformatf("r%0d_vcount", idx), vcount, 1);
    check($sformatf("r%0d_hold_st", idx), int'(status), int'(v.st));
    check($sformatf("r%0d_hold_res", idx), int'(result_ms), v.res);
`ifdef REACTION_BEST_EN
    if (v.st == 2'b01 && v.res < best_exp) best_exp = v.res;
    check($sformatf("r%0d_best", idx), int'(best_ms), best_exp);
`endif
  endtask

  initial begin
    int cnt;
    tbl[0]  = '{1'b0, 300, 1'b0, 2'b01, 300};
    tbl[1]  = '{1'b0, 200, 1'b0, 2'b01, 200};
    tbl[2]  = '{1'b0, 400, 1'b1, 2'b01, 400};
    tbl[3]  = '{1'b1, 10,  1'b0, 2'b10, 0};
    tbl[4]  = '{1'b0, 250, 1'b0, 2'b01, 250};
    tbl[5]  = '{1'b0, 40,  1'b1, 2'b01, 40};
    tbl[6]  = '{1'b1, -2,  1'b1, 2'b10, 0};
    tbl[7]  = '{1'b1, 10,  1'b1, 2'b10, 0};
    tbl[8]  = '{1'b0, 1,   1'b0, 2'b01, 1};
    tbl[9]  = '{1'b0, 0,   1'b0, 2'b01, 0};
    tbl[10] = '{1'b0, -1,  1'b0, 2'b11, 9999};

    repeat (2) @(posedge clk);
    #1;
    check("rst_stim", int'(stim_led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_result", int'(result_ms), 0);
    check("rst_status", int'(status), 0);
    check("rst_valid", int'(result_valid), 0);
`ifdef REACTION_BEST_EN
    check("rst_best", int'(best_ms), 16383);
`endif
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b1);
    check("idle_react", int'(busy) + int'(result_valid), 0);

    for (int i = 0; i < 11; i++) run(i);

    vcount = 0;
    step(1'b0, 1'b1, 1'b0);
    cnt = 0;
    while (!stim_led && cnt < 6000) begin
      step(1'b1, 1'b0, 1'b0);
      cnt++;
    end
    check("abort_in_go", int'(stim_led), 1);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("abort_stim", int'(stim_led), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result_ms), 0);
    check("abort_status", int'(status), 0);
`ifdef REACTION_BEST_EN
    check("abort_best", int'(best_ms), 16383);
`endif
    step(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b1);
    check("abort_no_valid", vcount, 0);
    check("abort_idle", int'(busy) + int'(stim_led) + int'(status), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
